// File: rtl/register_file_banked.sv
// Banked per-warp vector register file serving the operand-collector read ports.
//
// Each entry holds one warp-wide register (WarpWidth threads x RegWidth bits).
// Entry (wid, idx) lives in bank (wid + idx) mod NumBanks. Each bank does one
// access per cycle. A writeback takes its bank ahead of any read. Reads
// compete per bank under a round-robin pointer. Read data returns exactly
// one cycle after acceptance.
//
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   opc_read_req_valid_i     per-port read request valid
//   opc_read_req_wid_i       per-port warp id (packed, WidWidth each)
//   opc_read_req_reg_idx_i   per-port register index (packed, RegIdxWidth each)
//   opc_read_req_ready_o     per-port grant, forced low during reset
//   opc_read_rsp_valid_o     per-port response valid, one cycle after grant
//   opc_read_rsp_data_o      per-port warp-wide response data (packed)
//   wb_valid_i               writeback valid, always accepted
//   wb_wid_i, wb_dst_i       writeback warp id and register index
//   wb_act_mask_i            per-thread write enable
//   wb_data_i                writeback data, thread t at [t*RegWidth +: RegWidth]
module register_file_banked #(
    parameter int unsigned NumWarps    = 8,
    parameter int unsigned WarpWidth   = 32,
    parameter int unsigned RegIdxWidth = 6,
    parameter int unsigned RegWidth    = 32,
    parameter int unsigned NumPorts    = 2,
    parameter int unsigned NumBanks    = 2,
    parameter int unsigned WidWidth    = (NumWarps > 1) ? $clog2(NumWarps) : 1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [NumPorts-1:0]                   opc_read_req_valid_i,
    input  logic [NumPorts*WidWidth-1:0]          opc_read_req_wid_i,
    input  logic [NumPorts*RegIdxWidth-1:0]       opc_read_req_reg_idx_i,
    output logic [NumPorts-1:0]                   opc_read_req_ready_o,
    output logic [NumPorts-1:0]                   opc_read_rsp_valid_o,
    output logic [NumPorts*RegWidth*WarpWidth-1:0] opc_read_rsp_data_o,
    input  logic                                  wb_valid_i,
    input  logic [WidWidth-1:0]                   wb_wid_i,
    input  logic [RegIdxWidth-1:0]                wb_dst_i,
    input  logic [WarpWidth-1:0]                  wb_act_mask_i,
    input  logic [RegWidth*WarpWidth-1:0]         wb_data_i
);

    localparam int unsigned EntryWidth = RegWidth * WarpWidth;
    localparam int unsigned AddrWidth  = WidWidth + RegIdxWidth;
    localparam int unsigned NumEntries = NumWarps * (2 ** RegIdxWidth);
    localparam int unsigned BankWidth  = (NumBanks > 1) ? $clog2(NumBanks) : 1;
    localparam int unsigned RrWidth    = (NumPorts > 1) ? $clog2(NumPorts) : 1;

    if ((NumBanks & (NumBanks - 1)) != 0) begin : g_bad_num_banks
        $error("NumBanks must be a power of two");
    end

    // Only the low bits of wid and idx matter; the sum wraps modulo NumBanks.
    function automatic logic [BankWidth-1:0] bank_of(input logic [WidWidth-1:0]    wid,
                                                     input logic [RegIdxWidth-1:0] idx);
        logic [BankWidth-1:0] sum;
        sum = BankWidth'(wid) + BankWidth'(idx);
        return (NumBanks > 1) ? sum : '0;
    endfunction

    logic [EntryWidth-1:0]  mem_q      [NumEntries];
    logic [EntryWidth-1:0]  rsp_data_q [NumPorts];
    logic [NumPorts-1:0]    rsp_valid_q, rsp_valid_d;
    logic [RrWidth-1:0]     rr_q [NumBanks];
    logic [RrWidth-1:0]     rr_d [NumBanks];

    logic [WidWidth-1:0]    rd_wid  [NumPorts];
    logic [RegIdxWidth-1:0] rd_idx  [NumPorts];
    logic [AddrWidth-1:0]   rd_addr [NumPorts];
    logic [BankWidth-1:0]   rd_bank [NumPorts];
    logic [BankWidth-1:0]   wb_bank;
    logic [AddrWidth-1:0]   wb_addr;
    logic [NumPorts-1:0]    gnt;

    always_comb begin
        for (int unsigned p = 0; p < NumPorts; p++) begin
            rd_wid[RrWidth'(p)]  = opc_read_req_wid_i[p*WidWidth +: WidWidth];
            rd_idx[RrWidth'(p)]  = opc_read_req_reg_idx_i[p*RegIdxWidth +: RegIdxWidth];
            rd_addr[RrWidth'(p)] = {rd_wid[RrWidth'(p)], rd_idx[RrWidth'(p)]};
            rd_bank[RrWidth'(p)] = bank_of(rd_wid[RrWidth'(p)], rd_idx[RrWidth'(p)]);
        end
    end

    assign wb_bank = bank_of(wb_wid_i, wb_dst_i);
    assign wb_addr = {wb_wid_i, wb_dst_i};

    // Per bank: search ports upward from rr_q[b], wrapping; first requester wins.
    always_comb begin
        int unsigned sel;
        logic        found;
        sel = 0;
        gnt = '0;
        for (int unsigned b = 0; b < NumBanks; b++) begin
            rr_d[BankWidth'(b)] = rr_q[BankWidth'(b)];
            found = 1'b0;
            if (rst_ni && !(wb_valid_i && wb_bank == BankWidth'(b))) begin
                for (int unsigned k = 0; k < NumPorts; k++) begin
                    sel = (k + 32'(rr_q[BankWidth'(b)])) % NumPorts;
                    if (!found && opc_read_req_valid_i[RrWidth'(sel)] &&
                        rd_bank[RrWidth'(sel)] == BankWidth'(b)) begin
                        found               = 1'b1;
                        gnt[RrWidth'(sel)]  = 1'b1;
                        rr_d[BankWidth'(b)] = RrWidth'((sel + 1) % NumPorts);
                    end
                end
            end
        end
    end

    assign opc_read_req_ready_o = gnt;
    assign rsp_valid_d          = gnt;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rsp_valid_q <= '0;
            for (int unsigned b = 0; b < NumBanks; b++) rr_q[BankWidth'(b)] <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rr_q        <= rr_d;
        end
    end

    // Storage and response data are not reset. The read samples the entry
    // before this edge's write, which cannot hit the same bank anyway.
    always_ff @(posedge clk_i) begin
        for (int unsigned p = 0; p < NumPorts; p++) begin
            if (gnt[RrWidth'(p)]) rsp_data_q[RrWidth'(p)] <= mem_q[rd_addr[RrWidth'(p)]];
        end
        if (rst_ni && wb_valid_i) begin
            for (int unsigned t = 0; t < WarpWidth; t++) begin
                if (wb_act_mask_i[t]) mem_q[wb_addr][t*RegWidth +: RegWidth] <= wb_data_i[t*RegWidth +: RegWidth];
            end
        end
    end

    // Gating with rst_ni keeps a response from an accept just before reset invisible.
    assign opc_read_rsp_valid_o = rsp_valid_q & {NumPorts{rst_ni}};

    always_comb begin
        opc_read_rsp_data_o = '0;
        for (int unsigned p = 0; p < NumPorts; p++) begin
            opc_read_rsp_data_o[p*EntryWidth +: EntryWidth] = rsp_data_q[RrWidth'(p)];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            for (int unsigned p = 0; p < NumPorts; p++) begin
                for (int unsigned q = p + 1; q < NumPorts; q++) begin
                    if (gnt[RrWidth'(p)] && gnt[RrWidth'(q)]) begin
                        assert (rd_bank[RrWidth'(p)] != rd_bank[RrWidth'(q)])
                        else $error("two ports granted the same bank");
                    end
                end
            end
        end
    end

    for (genvar gp = 0; gp < NumPorts; gp++) begin : g_req_stable
        assert property (@(posedge clk_i) disable iff (!rst_ni)
            (opc_read_req_valid_i[gp] && !opc_read_req_ready_o[gp]) |=>
            (opc_read_req_valid_i[gp] &&
             $stable(opc_read_req_wid_i[gp*WidWidth +: WidWidth]) &&
             $stable(opc_read_req_reg_idx_i[gp*RegIdxWidth +: RegIdxWidth])))
        else $error("read request changed while waiting for ready");
    end

endmodule
